// File: rtl/aes_key_mem_pkg.sv
// Shared AES key-memory definitions: round counts, key-length encodings,
// the forward S-box and the GF(2^8) helpers used by the schedule and read path.
package aes_key_mem_pkg;

   localparam logic [3:0] NR128           = 4'd10;
   localparam logic [3:0] NR256           = 4'd14;
   localparam logic       AES_128_BIT_KEY = 1'b0;
   localparam logic       AES_256_BIT_KEY = 1'b1;
   localparam int         NUM_SLOTS       = 15;

   typedef enum logic {IDLE, GEN} key_mem_state_e;

   // Entry 0x00 occupies the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[{~b, 3'b111} -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 4; i++) begin
         if (k[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
              gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
              gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
              gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
   endfunction

   function automatic logic [127:0] inv_mix_key(input logic [127:0] k);
      return {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]),
              inv_mix_col(k[63:32]), inv_mix_col(k[31:0])};
   endfunction

endpackage

// File: rtl/aes_key_mem_if.sv
// Bundle between a cipher/decipher core (master) and the AES key memory (slave).
interface aes_key_mem_if;
   import aes_key_mem_pkg::*;

   // init is a request accepted on any edge where the key memory is IDLE and
   // ignored otherwise; ready is a level that stays high while every round key
   // is valid and drops on the edge that accepts a new init.
   logic           init;
   logic           keylen;
   logic [255:0]   key;
   logic           dec;
   logic [3:0]     round;
   logic [127:0]   round_key;
   logic           ready;
   key_mem_state_e state;

   modport master (output init, keylen, key, dec, round,
                   input  round_key, ready, state);
   modport slave  (input  init, keylen, key, dec, round,
                   output round_key, ready, state);
endinterface

// File: rtl/aes_sub_word.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word.
module aes_sub_word
   import aes_key_mem_pkg::*;
(
   input  logic [31:0] word,
   output logic [31:0] sub
);
   assign sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
endmodule

// File: rtl/aes_key_mem.sv
// Iterative AES-128/256 key expansion into a 15-slot round-key store, read
// combinationally in cipher order or equivalent-inverse-cipher order.
module aes_key_mem
   import aes_key_mem_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   aes_key_mem_if.slave bus
);
   key_mem_state_e state;
   logic           ready_r;
   logic           keylen_r;
   logic [3:0]     counter;
   logic [3:0]     nr;
   logic [7:0]     rcon;
   logic [127:0]   slot [NUM_SLOTS];

   logic [3:0]     p1_idx;
   logic [3:0]     p2_idx;
   logic [127:0]   prev1;
   logic [127:0]   prev2;
   logic [127:0]   base;
   logic [127:0]   next_key;
   logic           use_rcon;
   logic [31:0]    sub_in;
   logic [31:0]    sub_out;
   logic [31:0]    t;
   logic [31:0]    w0, w1, w2, w3;

   assign nr     = keylen_r ? NR256 : NR128;
   assign p1_idx = counter - 4'd1;
   assign p2_idx = counter - 4'd2;
   assign prev1  = slot[p1_idx];
   assign prev2  = slot[p2_idx];

   // AES-256 odd steps take SubWord alone; all other steps rotate and add rcon.
   assign use_rcon = (keylen_r == AES_128_BIT_KEY) || !counter[0];
   assign sub_in   = use_rcon ? {prev1[23:0], prev1[31:24]} : prev1[31:0];

   aes_sub_word u_sub_word (
      .word (sub_in),
      .sub  (sub_out)
   );

   assign t        = sub_out ^ (use_rcon ? {rcon, 24'h0} : 32'h0);
   assign base     = keylen_r ? prev2 : prev1;
   assign w0       = base[127:96] ^ t;
   assign w1       = base[95:64]  ^ w0;
   assign w2       = base[63:32]  ^ w1;
   assign w3       = base[31:0]   ^ w2;
   assign next_key = {w0, w1, w2, w3};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ready_r  <= 1'b0;
         keylen_r <= AES_128_BIT_KEY;
         counter  <= '0;
         rcon     <= 8'h01;
         for (int i = 0; i < NUM_SLOTS; i++) slot[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.init) begin
                  keylen_r <= bus.keylen;
                  slot[0]  <= bus.key[255:128];
                  if (bus.keylen == AES_256_BIT_KEY) begin
                     slot[1] <= bus.key[127:0];
                     counter <= 4'd2;
                  end else begin
                     counter <= 4'd1;
                  end
                  rcon    <= 8'h01;
                  ready_r <= 1'b0;
                  state   <= GEN;
               end
            end
            GEN: begin
               slot[counter] <= next_key;
               counter       <= counter + 4'd1;
               if (use_rcon) rcon <= xtime(rcon);
               if (counter == nr) begin
                  ready_r <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [3:0]   rd_idx;
   logic [127:0] rd_key;
   logic [127:0] round_key_c;

   // Decipher order walks the store backwards; only middle keys get InvMixColumns.
   always_comb begin
      rd_idx      = '0;
      round_key_c = '0;
      if (bus.round <= nr) rd_idx = bus.dec ? (nr - bus.round) : bus.round;
      rd_key = slot[rd_idx];
      if (bus.round > nr)
         round_key_c = '0;
      else if (bus.dec && (bus.round != 4'd0) && (bus.round != nr))
         round_key_c = inv_mix_key(rd_key);
      else
         round_key_c = rd_key;
   end

   assign bus.round_key = round_key_c;
   assign bus.ready     = ready_r;
   assign bus.state     = state;

endmodule
